// File: rtl/mul_exec_unit_pkg.sv
// mul_exec_unit_pkg: widths, default latency and stage record shared with the RS and broadcast consumers
package mul_exec_unit_pkg;
  localparam int TAG_W = 5;
  localparam int DATA_W = 32;
  localparam int MUL_LATENCY = 3;
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } stage_t;
endpackage

// File: rtl/mul_exec_unit_mul16x16_pp.sv
// mul16x16_pp: combinational 16x16 unsigned partial-product multiplier
module mul16x16_pp (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  // full 32-bit unsigned product of the two halves
  always_comb o_p = i_a * i_b;
endmodule

// File: rtl/mul_exec_unit.sv
// mul_exec_unit: pipelined 32x32 multiply unit returning the low product word on the MUL broadcast bus
module mul_exec_unit
  import mul_exec_unit_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic              iss_we,
  input  logic [TAG_W-1:0]  iss_dst,
  input  logic [TAG_W-1:0]  iss_dst_tag,
  input  logic [DATA_W-1:0] iss_val1,
  input  logic [DATA_W-1:0] iss_val2,
  input  logic              flush,
  output logic              we_MUL,
  output logic [TAG_W-1:0]  tag_MUL,
  output logic [TAG_W-1:0]  dst_MUL,
  output logic [DATA_W-1:0] val_MUL,
  output logic [3:0]        inflight
);
  localparam int DLY = LATENCY - 3;
  stage_t            r_s1;
  logic [DATA_W-1:0] r_b;
  stage_t            r_s2;
  logic [31:0]       r_lh;
  logic [31:0]       r_hl;
  stage_t            r_st [DLY:0];
  logic [31:0]       w_ll;
  logic [31:0]       w_lh;
  logic [31:0]       w_hl;
  logic [DATA_W-1:0] w_sum;
  mul16x16_pp u_ll (.i_a(r_s1.data[15:0]),  .i_b(r_b[15:0]),  .o_p(w_ll));
  mul16x16_pp u_lh (.i_a(r_s1.data[15:0]),  .i_b(r_b[31:16]), .o_p(w_lh));
  mul16x16_pp u_hl (.i_a(r_s1.data[31:16]), .i_b(r_b[15:0]),  .o_p(w_hl));
  // S1: capture the issued entry; ops that do not write a register, or that meet a flush, are dropped here
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_s1 <= '0;
      r_b  <= '0;
    end else begin
      r_s1 <= '{valid: iss_valid & iss_we & ~flush, tag: iss_dst_tag, dst: iss_dst, data: iss_val1};
      r_b  <= iss_val2;
    end
  // S2: register the partial products; AH*BH only affects bits above 31 so it is never formed
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_s2 <= '0;
      r_lh <= '0;
      r_hl <= '0;
    end else begin
      r_s2 <= '{valid: r_s1.valid & ~flush, tag: r_s1.tag, dst: r_s1.dst, data: w_ll};
      r_lh <= w_lh;
      r_hl <= w_hl;
    end
  // low word of the product: unsigned partial sums truncated to 32 bits equal the signed result
  always_comb w_sum = r_s2.data + ((r_lh + r_hl) << 16);
  // S3 result stage followed by pure delay stages; the last entry drives the broadcast bus
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int k = 0; k <= DLY; k++) r_st[k] <= '0;
    end else begin
      r_st[0] <= '{valid: r_s2.valid & ~flush, tag: r_s2.tag, dst: r_s2.dst, data: w_sum};
      for (int k = 1; k <= DLY; k++)
        r_st[k] <= '{valid: r_st[k-1].valid & ~flush, tag: r_st[k-1].tag, dst: r_st[k-1].dst, data: r_st[k-1].data};
    end
  // broadcast straight from the output stage register
  always_comb begin
    we_MUL  = r_st[DLY].valid;
    tag_MUL = r_st[DLY].tag;
    dst_MUL = r_st[DLY].dst;
    val_MUL = r_st[DLY].data;
  end
  // occupancy is the number of live stage valid bits
  always_comb begin
    inflight = 4'(r_s1.valid) + 4'(r_s2.valid);
    for (int k = 0; k <= DLY; k++) inflight = inflight + 4'(r_st[k].valid);
  end
endmodule

// File: tb/tb_mul_exec_unit.sv
// tb_mul_exec_unit: random and directed checks of the multiply unit at latency 3 and 5 against an op-queue model
module tb_mul_exec_unit;
  logic        clk = 0;
  logic        reset = 0;
  logic        iss_valid = 0;
  logic        iss_we = 0;
  logic [4:0]  iss_dst = 0;
  logic [4:0]  iss_dst_tag = 0;
  logic [31:0] iss_val1 = 0;
  logic [31:0] iss_val2 = 0;
  logic        flush = 0;
  logic        we3, we5;
  logic [4:0]  tag3, tag5, dst3, dst5;
  logic [31:0] val3, val5;
  logic [3:0]  inf3, inf5;
  int total = 0;
  int bad = 0;
  int e = 0;
  int peak3 = 0;
  typedef struct {
    int          lane;
    int          due;
    logic [4:0]  tag;
    logic [4:0]  dst;
    logic [31:0] val;
  } op_t;
  op_t q[$];

  mul_exec_unit #(.LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_we(iss_we), .iss_dst(iss_dst),
    .iss_dst_tag(iss_dst_tag), .iss_val1(iss_val1), .iss_val2(iss_val2), .flush(flush),
    .we_MUL(we3), .tag_MUL(tag3), .dst_MUL(dst3), .val_MUL(val3), .inflight(inf3));
  mul_exec_unit #(.LATENCY(5)) dut5 (
    .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_we(iss_we), .iss_dst(iss_dst),
    .iss_dst_tag(iss_dst_tag), .iss_val1(iss_val1), .iss_val2(iss_val2), .flush(flush),
    .we_MUL(we5), .tag_MUL(tag5), .dst_MUL(dst5), .val_MUL(val5), .inflight(inf5));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int lat, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s lat%0d observed=%0h expected=%0h", nm, lat, obs, exp);
    end
  endtask

  task automatic step(input logic rs, input logic v, input logic we, input logic fl,
                      input logic [4:0] tg, input logic [4:0] ds, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    reset = rs; iss_valid = v; iss_we = we; flush = fl;
    iss_dst_tag = tg; iss_dst = ds; iss_val1 = a; iss_val2 = b;
    @(posedge clk);
    e++;
    p = 32'($signed(a) * $signed(b));
    if (!rs || fl) q.delete();
    else if (v && we) begin
      q.push_back('{lane: 0, due: e + 2, tag: tg, dst: ds, val: p});
      q.push_back('{lane: 1, due: e + 4, tag: tg, dst: ds, val: p});
    end
    #1;
    for (int l = 0; l < 2; l++) begin
      logic        xwe;
      logic [4:0]  xtag, xdst;
      logic [31:0] xval;
      int          cnt;
      int          lat;
      xwe = 0; xtag = 0; xdst = 0; xval = 0; cnt = 0;
      lat = l == 0 ? 3 : 5;
      foreach (q[i]) if (q[i].lane == l) begin
        if (q[i].due == e) begin xwe = 1; xtag = q[i].tag; xdst = q[i].dst; xval = q[i].val; end
        if (q[i].due >= e) cnt++;
      end
      chk("we", lat, 32'(l == 0 ? we3 : we5), 32'(xwe));
      chk("inflight", lat, 32'(l == 0 ? inf3 : inf5), cnt);
      if (xwe || !rs) begin
        chk("tag", lat, 32'(l == 0 ? tag3 : tag5), 32'(xtag));
        chk("dst", lat, 32'(l == 0 ? dst3 : dst5), 32'(xdst));
        chk("val", lat, l == 0 ? val3 : val5, xval);
      end
    end
    if (32'(inf3) > peak3) peak3 = inf3;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].due <= e) q.delete(i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 5'(i + 1), 5'(i), $urandom, $urandom);
    step(1, 1, 1, 0, 9, 3, 7, 6);
    idle(6);
    step(1, 1, 1, 0, 1, 1, -32'sd3, 5);
    step(1, 1, 1, 0, 2, 2, 32'h0001_0000, 32'h0001_0000);
    step(1, 1, 1, 0, 0, 0, 32'h7FFF_FFFF, 2);
    idle(6);
    peak3 = 0;
    for (int i = 1; i <= 4; i++) step(1, 1, 1, 0, 5'(i), 5'(i + 8), i, i + 1);
    idle(6);
    chk("peak_inflight", 3, peak3, 3);
    step(1, 1, 0, 0, 7, 7, 9, 9);
    idle(6);
    step(1, 1, 1, 0, 10, 1, 3, 3);
    step(1, 1, 1, 0, 11, 2, 4, 4);
    step(1, 1, 1, 1, 12, 3, 5, 5);
    idle(1);
    step(1, 1, 1, 0, 13, 4, 123, 456);
    idle(6);
    step(1, 1, 1, 0, 14, 5, 11, 13);
    idle(1);
    step(0, 1, 1, 0, 15, 6, 2, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(6);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
           $urandom_range(0, 24) == 0, 5'($urandom), 5'($urandom), $urandom, $urandom);
    idle(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
